pll_lock_sequencer: RTL and testbench

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

---
 rtl/pll_lock_sequencer.sv | 160 ++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: pulses the PLL reset, waits for a synchronized lock, holds
// the downstream reset until lock has been stable, and retries or fails on timeout.
module pll_lock_sequencer #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 50000,
  parameter int LOCK_STABLE  = 1024,
  parameter int MAX_RETRIES  = 7
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       force_relock,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_count,
  output logic [7:0] lock_loss_count,
  output logic [2:0] dbg_state
);

  localparam int MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX = (MAX_AB > LOCK_STABLE) ? MAX_AB : LOCK_STABLE;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
  // The WAIT_LOCK cycle that first sees lock counts as stable cycle one, so
  // STABILIZE itself only has to observe LOCK_STABLE-1 further locked cycles.
  localparam logic [CW-1:0] STAB_LAST = CW'((LOCK_STABLE >= 2) ? LOCK_STABLE - 2 : 0);
  localparam logic [3:0]    RETRY_LIM = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABILIZE = 3'd2,
    S_RUN       = 3'd3,
    S_FAILED    = 3'd4
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_sync_meta;
  logic          r_locked_s;
  logic [3:0]    r_retry;
  logic [7:0]    r_loss;
  logic          r_pll_rst;
  logic          r_sys_rst;
  logic          r_ready;
  logic          r_fail;

  logic [3:0]    w_retry_inc;
  logic [7:0]    w_loss_next;

  assign w_retry_inc = r_retry + 4'd1;
  assign w_loss_next = (r_loss == 8'hFF) ? r_loss : r_loss + 8'd1;

  // pll_locked is asynchronous to refclk; only r_locked_s is used by the FSM.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_sync_meta <= 1'b0;
      r_locked_s  <= 1'b0;
    end else begin
      r_sync_meta <= pll_locked;
      r_locked_s  <= r_sync_meta;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state   <= S_RESET_PLL;
      r_cnt     <= '0;
      r_retry   <= 4'd0;
      r_loss    <= 8'd0;
      r_pll_rst <= 1'b1;
      r_sys_rst <= 1'b1;
      r_ready   <= 1'b0;
      r_fail    <= 1'b0;
    end else begin
      // Outputs are decoded from the current state, so they trail each transition by one cycle.
      r_pll_rst <= (r_state == S_RESET_PLL) || (r_state == S_FAILED);
      r_sys_rst <= (r_state != S_RUN);
      r_ready   <= (r_state == S_RUN);
      r_fail    <= (r_state == S_FAILED);
      r_cnt     <= r_cnt + CW'(1);

      case (r_state)
        S_RESET_PLL: begin
          if (force_relock) begin
            r_cnt <= '0;
          end else if (r_cnt == RST_LAST) begin
            r_state <= S_WAIT_LOCK;
            r_cnt   <= '0;
          end
        end

        S_WAIT_LOCK: begin
          if (force_relock) begin
            r_state <= S_RESET_PLL;
            r_cnt   <= '0;
          end else if (r_locked_s) begin
            r_state <= S_STABILIZE;
            r_cnt   <= '0;
          end else if (r_cnt == TO_LAST) begin
            r_retry <= w_retry_inc;
            r_cnt   <= '0;
            r_state <= (w_retry_inc == RETRY_LIM) ? S_FAILED : S_RESET_PLL;
          end
        end

        S_STABILIZE: begin
          if (force_relock) begin
            r_state <= S_RESET_PLL;
            r_cnt   <= '0;
          end else if (!r_locked_s) begin
            r_state <= S_WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == STAB_LAST) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
            r_retry <= 4'd0;
          end
        end

        S_RUN: begin
          r_cnt <= '0;
          // A lock loss is counted even when force_relock arrives in the same cycle.
          if (!r_locked_s) begin
            r_loss  <= w_loss_next;
            r_state <= S_RESET_PLL;
          end else if (force_relock) begin
            r_state <= S_RESET_PLL;
          end
        end

        S_FAILED: begin
          r_cnt <= '0;
          if (force_relock) begin
            r_retry <= 4'd0;
            r_state <= S_RESET_PLL;
          end
        end

        default: begin
          r_state <= S_RESET_PLL;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign pll_rst         = r_pll_rst;
  assign sys_rst         = r_sys_rst;
  assign ready           = r_ready;
  assign fail            = r_fail;
  assign retry_count     = r_retry;
  assign lock_loss_count = r_loss;
  assign dbg_state       = r_state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer: clean lock, loss in RUN, simultaneous
// events, saturation, reset mid-sequence, timeout to FAILED and a STABILIZE glitch.
module tb_pll_lock_sequencer;

  localparam logic [2:0] ST_RESET = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_STAB  = 3'd2;
  localparam logic [2:0] ST_FAIL  = 3'd4;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       force_relock = 1'b0;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fail;
  logic [3:0] retry_count;
  logic [7:0] lock_loss_count;
  logic [2:0] dbg_state;

  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  pll_lock_sequencer #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(20), .LOCK_STABLE(8), .MAX_RETRIES(2)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .force_relock(force_relock),
    .pll_rst(pll_rst), .sys_rst(sys_rst), .ready(ready), .fail(fail),
    .retry_count(retry_count), .lock_loss_count(lock_loss_count), .dbg_state(dbg_state)
  );

  always #5 refclk = ~refclk;

  task automatic cyc();
    @(posedge refclk);
    #1;
  endtask

  task automatic cycles(input int k);
    for (int i = 0; i < k; i++) cyc();
  endtask

  function automatic logic sig(input int sel);
    logic v;
    case (sel)
      0:       v = pll_rst;
      1:       v = sys_rst;
      2:       v = ready;
      default: v = fail;
    endcase
    return v;
  endfunction

  task automatic wait_until(input int sel, input logic val, input int max, output int n);
    n = 0;
    while (sig(sel) !== val && n < max) begin
      cyc();
      n++;
    end
  endtask

  task automatic count_level(input int sel, input logic val, input int max, output int n);
    n = 0;
    while (sig(sel) === val && n < max) begin
      n++;
      cyc();
    end
  endtask

  task automatic check_pop(input string tag, input logic [15:0] observed);
    logic [15:0] e;
    e = exp_q.pop_front();
    n_checks++;
    assert (observed === e) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, e);
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    exp_q.push_back(expected);
    check_pop(tag, observed);
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_pll_rst"}, 16'(pll_rst), 16'd1);
    chk({pfx, "_sys_rst"}, 16'(sys_rst), 16'd1);
    chk({pfx, "_ready"}, 16'(ready), 16'd0);
    chk({pfx, "_fail"}, 16'(fail), 16'd0);
    chk({pfx, "_retry"}, 16'(retry_count), 16'd0);
    chk({pfx, "_loss"}, 16'(lock_loss_count), 16'd0);
    chk({pfx, "_state"}, 16'(dbg_state), 16'(ST_RESET));
  endtask

  initial begin
    int n;
    int to_cnt;

    // Reset values
    rst = 1'b1;
    cycles(3);
    check_reset_outputs("rst");

    // Clean lock: 4-cycle PLL reset, lock raised 5 cycles after it falls
    rst = 1'b0;
    cyc();
    exp_q.push_back(16'd4);
    count_level(0, 1'b1, 50, n);
    check_pop("clean_pll_rst_len", 16'(n));
    cycles(5);
    pll_locked = 1'b1;
    exp_q.push_back(16'd11);
    wait_until(2, 1'b1, 40, n);
    check_pop("clean_ready_latency", 16'(n));
    chk("clean_sys_rst", 16'(sys_rst), 16'd0);
    chk("clean_retry", 16'(retry_count), 16'd0);
    chk("clean_fail", 16'(fail), 16'd0);

    // Loss in RUN
    pll_locked = 1'b0;
    exp_q.push_back(16'd0);
    cyc();
    wait_until(2, 1'b0, 3, n);
    check_pop("loss_ready_within_3", 16'(ready));
    chk("loss_sys_rst", 16'(sys_rst), 16'd1);
    chk("loss_count_1", 16'(lock_loss_count), 16'd1);
    exp_q.push_back(16'd4);
    count_level(0, 1'b1, 50, n);
    check_pop("loss_pll_rst_len", 16'(n));
    pll_locked = 1'b1;
    exp_q.push_back(16'd11);
    wait_until(2, 1'b1, 40, n);
    check_pop("loss_relock_latency", 16'(n));

    // force_relock and synchronized lock drop reach the FSM in the same cycle
    pll_locked = 1'b0;
    cycles(2);
    force_relock = 1'b1;
    cyc();
    force_relock = 1'b0;
    chk("simul_state", 16'(dbg_state), 16'(ST_RESET));
    chk("simul_loss", 16'(lock_loss_count), 16'd2);
    wait_until(0, 1'b1, 10, n);
    wait_until(0, 1'b0, 10, n);
    pll_locked = 1'b1;
    wait_until(2, 1'b1, 20, n);
    chk("simul_relock", 16'(ready), 16'd1);

    // force_relock while locked: restart without counting a loss
    force_relock = 1'b1;
    cyc();
    force_relock = 1'b0;
    chk("force_state", 16'(dbg_state), 16'(ST_RESET));
    chk("force_loss", 16'(lock_loss_count), 16'd2);
    cyc();
    chk("force_ready_low", 16'(ready), 16'd0);
    wait_until(2, 1'b1, 40, n);
    chk("force_relock", 16'(ready), 16'd1);

    // 300 more losses: counter saturates
    to_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b0;
      cyc();
      wait_until(2, 1'b0, 5, n);
      if (ready !== 1'b0) to_cnt++;
      wait_until(0, 1'b0, 10, n);
      if (pll_rst !== 1'b0) to_cnt++;
      pll_locked = 1'b1;
      wait_until(2, 1'b1, 20, n);
      if (ready !== 1'b1) to_cnt++;
    end
    chk("sat_loop_timeouts", 16'(to_cnt), 16'd0);
    chk("sat_loss_255", 16'(lock_loss_count), 16'd255);

    // One more loss stays at 255, then rst in the middle of WAIT_LOCK
    pll_locked = 1'b0;
    cyc();
    wait_until(2, 1'b0, 5, n);
    chk("sat_loss_hold", 16'(lock_loss_count), 16'd255);
    wait_until(0, 1'b0, 10, n);
    chk("midwait_state", 16'(dbg_state), 16'(ST_WAIT));
    cycles(3);
    rst = 1'b1;
    cyc();
    check_reset_outputs("midwait_rst");

    // Timeout to FAILED with lock held low
    rst = 1'b0;
    cyc();
    exp_q.push_back(16'd4);
    count_level(0, 1'b1, 50, n);
    check_pop("to_pulse1_len", 16'(n));
    exp_q.push_back(16'd20);
    count_level(0, 1'b0, 50, n);
    check_pop("to_wait1_len", 16'(n));
    chk("to_retry_1", 16'(retry_count), 16'd1);
    exp_q.push_back(16'd4);
    count_level(0, 1'b1, 50, n);
    check_pop("to_pulse2_len", 16'(n));
    exp_q.push_back(16'd20);
    count_level(0, 1'b0, 50, n);
    check_pop("to_wait2_len", 16'(n));
    chk("to_fail", 16'(fail), 16'd1);
    chk("to_retry_2", 16'(retry_count), 16'd2);
    chk("to_pll_rst", 16'(pll_rst), 16'd1);
    cycles(10);
    chk("failed_pll_rst_held", 16'(pll_rst), 16'd1);
    chk("failed_fail_held", 16'(fail), 16'd1);
    chk("failed_state", 16'(dbg_state), 16'(ST_FAIL));

    // force_relock out of FAILED
    force_relock = 1'b1;
    cyc();
    force_relock = 1'b0;
    chk("exit_retry_clr", 16'(retry_count), 16'd0);
    cyc();
    chk("exit_fail_low", 16'(fail), 16'd0);
    exp_q.push_back(16'd4);
    count_level(0, 1'b1, 50, n);
    check_pop("exit_pulse_len", 16'(n));

    // One timeout, then a one-cycle lock glitch at stable count 5
    exp_q.push_back(16'd20);
    count_level(0, 1'b0, 50, n);
    check_pop("glitch_wait_len", 16'(n));
    exp_q.push_back(16'd4);
    count_level(0, 1'b1, 50, n);
    check_pop("glitch_pulse_len", 16'(n));
    chk("glitch_retry_pre", 16'(retry_count), 16'd1);
    cycles(2);
    pll_locked = 1'b1;
    cycles(5);
    pll_locked = 1'b0;
    cyc();
    pll_locked = 1'b1;
    cycles(2);
    chk("glitch_back_to_wait", 16'(dbg_state), 16'(ST_WAIT));
    cyc();
    chk("glitch_restabilize", 16'(dbg_state), 16'(ST_STAB));
    chk("glitch_retry_kept", 16'(retry_count), 16'd1);
    exp_q.push_back(16'd8);
    wait_until(2, 1'b1, 20, n);
    check_pop("glitch_ready_latency", 16'(n));
    chk("glitch_retry_clr_run", 16'(retry_count), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
